// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4-channel round-robin mux arbiter.
package rr_mux_arbiter_pkg;

   localparam int NUM_CH      = 4;
   localparam int SEL_W       = 2;
   localparam int STATS_CNT_W = 16;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // One-hot channel vector for a select code.
   function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t s);
      logic [NUM_CH-1:0] one;
      one = {{(NUM_CH-1){1'b0}}, 1'b1};
      return one << s;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches ptr+1 .. ptr+4 (mod 4) and
// returns the first requesting channel. Reusable by any scheduler that
// feeds the 4:1 case mux.
module rr_pick4
   import rr_mux_arbiter_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  sel_t              ptr,
   output logic              any,
   output sel_t              winner
);

   sel_t idx;
   logic found;

   // Rotating priority search starting just after the last grant.
   always_comb begin
      any    = |req;
      winner = ptr;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = ptr + sel_t'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Registered 4-channel round-robin arbiter upstream of the 4:1 case mux.
// Optional per-channel grant counters: define RR_MUX_ARBITER_STATS_EN.
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | output register holds nothing (out_valid=0)
// FULL  | output register holds a word  (out_valid=1)
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int DATA_W    = 2,
   parameter int RESET_PTR = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   output logic [NUM_CH-1:0]        req_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_src,
   input  logic                     out_ready
`ifdef RR_MUX_ARBITER_STATS_EN
   ,
   output logic [NUM_CH*STATS_CNT_W-1:0] grant_cnt
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   sel_t              out_src_q, out_src_d;
   sel_t              ptr_q, ptr_d;

   logic              any;
   sel_t              winner;
   logic              load;
   logic              drain;
   logic [DATA_W-1:0] win_data;

   rr_pick4 u_pick (
      .req    (req_valid),
      .ptr    (ptr_q),
      .any    (any),
      .winner (winner)
   );

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

   // Handshake decode, grant and next-state of the output stage.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      ptr_d      = ptr_q;
      drain      = out_valid & out_ready;
      load       = any & (!out_valid | out_ready);
      win_data   = req_data[int'(winner)*DATA_W +: DATA_W];
      req_ready  = '0;
      if (load && !rst) begin
         req_ready = sel_onehot(winner);
      end
      if (load) begin
         state_d    = FULL;
         out_data_d = win_data;
         out_src_d  = winner;
         ptr_d      = winner;
      end else if (drain) begin
         state_d = EMPTY;
      end
   end

   // Output stage and last-grant pointer; reset discards any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_src_q  <= '0;
         ptr_q      <= sel_t'(RESET_PTR);
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         ptr_q      <= ptr_d;
      end
   end

`ifdef RR_MUX_ARBITER_STATS_EN
   logic [STATS_CNT_W-1:0] cnt_q [NUM_CH];
   logic [STATS_CNT_W-1:0] cnt_d [NUM_CH];

   // Saturating per-channel grant counters.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + STATS_CNT_W'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Pack counters onto the flat output, channel 0 in the low bits.
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, random
// scoreboard phase and (with RR_MUX_ARBITER_STATS_EN) counter checks.
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] req_data;
   logic [3:0] req_ready;
   logic       out_valid;
   logic [1:0] out_data;
   logic [1:0] out_src;
   logic       out_ready;
`ifdef RR_MUX_ARBITER_STATS_EN
   logic [63:0] grant_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   rr_mux_arbiter #(.DATA_W(2), .RESET_PTR(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
`ifdef RR_MUX_ARBITER_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [7:0] d;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [1:0] e_src;
      logic [1:0] e_data;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
   task automatic run_vec(input vec_t t, input int idx);
      @(posedge clk);
      #1;
      rst       = t.rst;
      req_valid = t.v;
      req_data  = t.d;
      out_ready = t.ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", idx), 64'(req_ready), 64'(t.e_rdy));
      chk($sformatf("vec%0d_out_valid", idx), 64'(out_valid), 64'(t.e_ov));
      chk($sformatf("vec%0d_out_src", idx),   64'(out_src),   64'(t.e_src));
      chk($sformatf("vec%0d_out_data", idx),  64'(out_data),  64'(t.e_data));
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int off = 1; off <= 4; off++) begin
         if (v[(p + off) % 4]) return (p + off) % 4;
      end
      return p;
   endfunction

   task automatic add(input logic r, input logic [3:0] v, input logic [7:0] d, input logic o,
                      input logic [3:0] er, input logic eov, input logic [1:0] es,
                      input logic [1:0] ed);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.ordy = o;
      t.e_rdy = er; t.e_ov = eov; t.e_src = es; t.e_data = ed;
      tbl.push_back(t);
   endtask

   logic [3:0] sb[$];
   int         m_ptr;
   int         m_w;
   logic       m_load;
   logic [3:0] rv;
   logic [7:0] rd;
   logic       ro;
   logic [3:0] e_rdy;

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;

      // reset then idle: 10 cycles
      for (int i = 0; i < 10; i++) add(0, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 2'd0);
      // full contention from ptr=3: grants 0,1,2,3,0,1
      add(0, 4'b1111, 8'hE4, 1, 4'b0001, 0, 2'd0, 2'd0);
      add(0, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd0, 2'd0);
      add(0, 4'b1111, 8'hE4, 1, 4'b0100, 1, 2'd1, 2'd1);
      add(0, 4'b1111, 8'hE4, 1, 4'b1000, 1, 2'd2, 2'd2);
      add(0, 4'b1111, 8'hE4, 1, 4'b0001, 1, 2'd3, 2'd3);
      add(0, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd0, 2'd0);
      add(0, 4'b0000, 8'hE4, 1, 4'b0000, 1, 2'd1, 2'd1);
      add(0, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd1, 2'd1);
      // backpressure on ch2 (data 2'b10), then release with ch0 also pending
      add(0, 4'b0100, 8'h20, 0, 4'b0100, 0, 2'd1, 2'd1);
      for (int i = 0; i < 4; i++) add(0, 4'b0100, 8'h20, 0, 4'b0000, 1, 2'd2, 2'd2);
      add(0, 4'b0101, 8'h21, 1, 4'b0001, 1, 2'd2, 2'd2);
      add(0, 4'b0000, 8'h00, 1, 4'b0000, 1, 2'd0, 2'd1);
      // wrap and skip: ptr=2, requests on ch1 and ch3 only
      add(0, 4'b0100, 8'h20, 1, 4'b0100, 0, 2'd0, 2'd1);
      add(0, 4'b1010, 8'hC4, 1, 4'b1000, 1, 2'd2, 2'd2);
      add(0, 4'b0010, 8'hC4, 1, 4'b0010, 1, 2'd3, 2'd3);
      add(0, 4'b0000, 8'h00, 1, 4'b0000, 1, 2'd1, 2'd1);
      // reset mid-operation with a held ch1 word
      add(0, 4'b0010, 8'h04, 0, 4'b0010, 0, 2'd1, 2'd1);
      add(1, 4'b0010, 8'h04, 1, 4'b0000, 1, 2'd1, 2'd1);
      add(0, 4'b1111, 8'hE4, 1, 4'b0001, 0, 2'd0, 2'd0);
      add(0, 4'b0000, 8'h00, 1, 4'b0000, 1, 2'd0, 2'd0);

      repeat (2) @(posedge clk);
      foreach (tbl[i]) run_vec(tbl[i], i);

      // random traffic against a scoreboard model
      @(posedge clk); #1;
      rst = 1'b1; req_valid = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = 3;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         rv = 4'($urandom_range(0, 15));
         rd = 8'($urandom);
         ro = ($urandom_range(0, 3) != 0);
         req_valid = rv; req_data = rd; out_ready = ro;
         @(negedge clk);
         chk("sb_out_valid", 64'(out_valid), 64'(sb.size() != 0));
         if (sb.size() != 0) chk("sb_out_word", 64'({out_src, out_data}), 64'(sb[0]));
         m_load = (rv != 0) && ((sb.size() == 0) || ro);
         m_w    = pick(rv, m_ptr);
         e_rdy  = m_load ? 4'(1 << m_w) : 4'b0000;
         chk("sb_req_ready", 64'(req_ready), 64'(e_rdy));
         if (sb.size() != 0 && ro) void'(sb.pop_front());
         if (m_load) begin
            sb.push_back({2'(m_w), rd[m_w*2 +: 2]});
            m_ptr = m_w;
         end
      end

`ifdef RR_MUX_ARBITER_STATS_EN
      @(posedge clk); #1;
      rst = 1'b1; req_valid = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0010; req_data = 8'h04;
      repeat (7) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("stats_ch1_seven", grant_cnt, {16'd0, 16'd0, 16'd7, 16'd0});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0001;
      repeat (65540) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("stats_ch0_saturate", grant_cnt, {16'd0, 16'd0, 16'd0, 16'hFFFF});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Registered 4-channel round-robin arbiter that sits directly upstream of the team's 4:1 case mux.
- Each channel has a valid/ready handshake. The block picks one pending channel per transfer.
- It drives the 2-bit select code (out_src) in the same encoding the mux uses: 0→in0 … 3→in3.
- It registers the winning channel's data into a single output stage with its own valid/ready handshake.

Parameters:
- DATA_W, 2: width of each channel's data and of out_data.
- RESET_PTR, 3: last-grant pointer value after reset; the default gives channel 0 first priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-channel request valid; bit i = channel i.
- req_data  input  4*DATA_W  packed channel data; channel i occupies [i*DATA_W +: DATA_W].
- req_ready  output  4  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a transfer.
- out_data  output  DATA_W  registered data of the granted channel.
- out_src  output  2  registered select code of the granted channel (0..3).
- out_ready  input  1  downstream accept.

Behaviour:
- Reset:
  - Taken on a clk edge while rst=1; reset wins over every other event.
  - out_valid=0, out_data=0, out_src=0, last-grant pointer=RESET_PTR, FSM=EMPTY.
  - req_ready is 0 while rst=1.
  - Reset mid-transfer discards the held word; no handshake completes on that edge.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Definitions:
  - drain = out_valid & out_ready.
  - load = (|req_valid) & (!out_valid | out_ready).
- Winner selection:
  - Search channels in order ptr+1, ptr+2, ptr+3, ptr+4, all mod 4 (2-bit wrap, 3→0).
  - The winner is the first channel with req_valid=1.
  - Search is combinational from current req_valid and ptr.
- req_ready[w] = load for the winner w; all other req_ready bits are 0. Any req_ready bit may depend combinationally on req_valid and out_ready.
- On a load edge:
  - out_data ← the winner's data slice; out_src ← w.
  - ptr ← w; out_valid ← 1.
  - Next state is FULL.
- Transitions:
  - EMPTY→FULL on load.
  - FULL→FULL on drain & load (back-to-back, throughput 1 word/cycle).
  - FULL→EMPTY on drain & !load.
  - FULL holds when !out_ready.
- Latency: a request accepted at edge k is visible on out_* right after edge k (1 cycle).
- Stability: while out_valid=1 and out_ready=0, out_data and out_src hold constant and ptr does not move.
- No requests: ptr is unchanged; the state goes EMPTY after a drain.
- Single requester: it is granted every cycle that load is true (no forced idle).
- Fairness: with all 4 channels valid continuously and out_ready=1, the grant order is strictly 0,1,2,3,0,… starting from RESET_PTR+1.
- Upstream contract: a channel must hold req_valid and req_data stable until its req_ready; the block does not check this.

Optional Feature:
- Macro: RR_MUX_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt, 4*16 bits: one 16-bit saturating counter per channel, incremented on each edge where req_valid[i]&req_ready[i].
  - Counters reset to 0 on rst and saturate at 16'hFFFF.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: NUM_CH=4, SEL_W=2, typedef state_t {EMPTY, FULL}, typedef sel_t (2-bit), STATS_CNT_W=16.
- One natural sub-module: rr_pick4.
  - Purely combinational: inputs req[3:0] and ptr[1:0]; outputs any and winner[1:0].
  - Instantiated once; reusable by other schedulers feeding the mux.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req_valid=0 → out_valid=0, out_data=0, out_src=0, req_ready=0000 for 10 cycles.
- Full contention: all channels valid, data ch0..3 = 0,1,2,3, out_ready=1 → out_src/out_data sequence 0,1,2,3,0,1; exactly one req_ready bit per cycle.
- Backpressure: ch2 valid with data 2'b10, out_ready=0 for 5 cycles:
  - out_valid=1, out_src=2, out_data=2'b10 held.
  - req_ready=0000 after the first accept.
  - Raising out_ready drains on that edge and loads the next request in the same cycle.
- Wrap and skip: ptr=2 (ch2 last granted), requests on ch1 and ch3 only → ch3 granted, then ch1; ch0/ch2 req_ready never asserted.
- Reset mid-operation: out_valid=1 with out_src=1, assert rst with out_ready=1 → next cycle out_valid=0, ptr=RESET_PTR; after release with all channels valid, first grant is ch0.
- STATS (macro defined): 7 grants to ch1 → grant_cnt[31:16]=7, other counters 0; force 65540 grants to ch0 → ch0 counter saturates at 16'hFFFF.
